// File: rtl/parser_seg_gather_if.sv
// Ingress AXI-Stream bundle seen by the parser front end.
// Handshake: a beat transfers in a cycle where tvalid and tready are both
// high. The parser only observes the stream, so every signal is an input on
// the slave side, including tready.
interface parser_seg_gather_if #(
   parameter int DATA_WIDTH  = 512,
   parameter int TUSER_WIDTH = 128
);
   logic [DATA_WIDTH-1:0]   tdata;
   logic [DATA_WIDTH/8-1:0] tkeep;
   logic [TUSER_WIDTH-1:0]  tuser;
   logic                    tlast;
   logic                    tvalid;
   logic                    tready;

   modport master (output tdata, tkeep, tuser, tlast, tvalid, tready);
   modport slave  (input  tdata, tkeep, tuser, tlast, tvalid, tready);
endinterface

// File: rtl/parser_seg_gather.sv
// Parser front end: gathers the first C_NUM_SEGS beats and the first-beat
// tuser of every packet, fetches the per-VLAN action word from the parser
// RAM, and presents {segs, tuser, action} as a single-cycle pulse two cycles
// after the beat that completes the gather. The stream is never stalled.
module parser_seg_gather #(
   parameter int C_AXIS_DATA_WIDTH  = 512,
   parameter int C_AXIS_TUSER_WIDTH = 128,
   parameter int C_NUM_SEGS         = 2,
   parameter int C_PARSER_RAM_WIDTH = 160,
   parameter int C_RAM_ADDR_WIDTH   = 5
) (
   input  logic                                     clk,
   input  logic                                     areset,
   parser_seg_gather_if.slave                       s_axis,
   output logic                                     ram_rd_en,
   output logic [C_RAM_ADDR_WIDTH-1:0]              ram_rd_addr,
   input  logic [C_PARSER_RAM_WIDTH-1:0]            ram_rd_data,
   output logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0]  segs_out,
   output logic                                     segs_out_valid,
   output logic [C_AXIS_TUSER_WIDTH-1:0]            tuser_1st_out,
   output logic [C_PARSER_RAM_WIDTH-1:0]            bram_out,
   output logic                                     bram_out_valid,
   output logic [31:0]                              pkt_cnt,
   output logic [1:0]                               fsm_state
);

   localparam int W      = C_AXIS_DATA_WIDTH;
   localparam int KB     = C_AXIS_DATA_WIDTH / 8;
   localparam int SEGS_W = C_NUM_SEGS * C_AXIS_DATA_WIDTH;
   localparam int CNT_W  = 2;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(C_NUM_SEGS - 1);

   // IDLE waits for SOP, GATHER collects further segments, DRAIN skips the
   // remainder of a packet longer than C_NUM_SEGS beats.
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_GATHER = 2'd1;
   localparam logic [1:0] ST_DRAIN  = 2'd2;

   logic [1:0]                      state_q, state_next;
   logic [CNT_W-1:0]                cnt_q, cnt_next;
   logic [SEGS_W-1:0]               seg_q, seg_next;
   logic [C_AXIS_TUSER_WIDTH-1:0]   tuser_q, tuser_next;
   logic                            beat, sop, done;
   logic [W-1:0]                    beat_masked;
   logic [11:0]                     vlan_id;

   logic                            rd_pend;
   logic [C_PARSER_RAM_WIDTH-1:0]   ram_hold;

   logic                            s1_valid;
   logic                            s1_direct;
   logic [SEGS_W-1:0]               s1_segs;
   logic [C_AXIS_TUSER_WIDTH-1:0]   s1_tuser;

   assign beat      = s_axis.tvalid & s_axis.tready;
   assign vlan_id   = {s_axis.tdata[115:112], s_axis.tdata[127:120]};
   assign fsm_state = state_q;

   // Zero the bytes whose keep bit is clear so stale payload never reaches the parser.
   always_comb begin
      beat_masked = '0;
      for (int b = 0; b < KB; b++) begin
         if (s_axis.tkeep[b]) begin
            beat_masked[b*8 +: 8] = s_axis.tdata[b*8 +: 8];
         end
      end
   end

   // The action lookup is issued in the SOP cycle itself; suppressed while in reset.
   always_comb begin
      ram_rd_en   = sop & ~areset;
      ram_rd_addr = '0;
      if (sop && !areset) begin
         ram_rd_addr = C_RAM_ADDR_WIDTH'(vlan_id >> 4);
      end
   end

   // Gather FSM next-state, segment merge and completion detect.
   always_comb begin
      state_next = state_q;
      cnt_next   = cnt_q;
      seg_next   = seg_q;
      tuser_next = tuser_q;
      sop        = 1'b0;
      done       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (beat) begin
               sop           = 1'b1;
               seg_next      = '0;
               seg_next[0 +: W] = beat_masked;
               tuser_next    = s_axis.tuser;
               cnt_next      = '0;
               if (LAST_IDX == '0 || s_axis.tlast) begin
                  done       = 1'b1;
                  state_next = s_axis.tlast ? ST_IDLE : ST_DRAIN;
               end else begin
                  cnt_next   = CNT_W'(1);
                  state_next = ST_GATHER;
               end
            end
         end
         ST_GATHER: begin
            if (beat) begin
               for (int k = 0; k < C_NUM_SEGS; k++) begin
                  if (cnt_q == CNT_W'(k)) begin
                     seg_next[k*W +: W] = beat_masked;
                  end
               end
               if (cnt_q == LAST_IDX || s_axis.tlast) begin
                  done       = 1'b1;
                  cnt_next   = '0;
                  state_next = s_axis.tlast ? ST_IDLE : ST_DRAIN;
               end else begin
                  cnt_next   = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_DRAIN: begin
            if (beat && s_axis.tlast) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // Capture registers and FSM state.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         seg_q   <= '0;
         tuser_q <= '0;
      end else begin
         state_q <= state_next;
         cnt_q   <= cnt_next;
         seg_q   <= seg_next;
         tuser_q <= tuser_next;
      end
   end

   // Hold the RAM word returned the cycle after the lookup for multi-beat packets.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         rd_pend  <= 1'b0;
         ram_hold <= '0;
      end else begin
         rd_pend <= ram_rd_en;
         if (rd_pend) begin
            ram_hold <= ram_rd_data;
         end
      end
   end

   // Stage 1: freeze the completed packet so new captures can start immediately.
   // A packet completed in IDLE is single-cycle, so its RAM word arrives next cycle.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         s1_valid  <= 1'b0;
         s1_direct <= 1'b0;
         s1_segs   <= '0;
         s1_tuser  <= '0;
      end else begin
         s1_valid <= done;
         if (done) begin
            s1_direct <= (state_q == ST_IDLE);
            s1_segs   <= seg_next;
            s1_tuser  <= tuser_next;
         end
      end
   end

   // Output stage: single-cycle pulse, data held between pulses, packet count.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         segs_out       <= '0;
         segs_out_valid <= 1'b0;
         tuser_1st_out  <= '0;
         bram_out       <= '0;
         bram_out_valid <= 1'b0;
         pkt_cnt        <= '0;
      end else begin
         segs_out_valid <= s1_valid;
         bram_out_valid <= s1_valid;
         if (s1_valid) begin
            segs_out      <= s1_segs;
            tuser_1st_out <= s1_tuser;
            bram_out      <= s1_direct ? ram_rd_data : ram_hold;
            pkt_cnt       <= pkt_cnt + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_parser_seg_gather.sv
// Bench for parser_seg_gather: randomized packets against a packet-level
// reference model (expected segs/tuser/action/pulse cycle per packet).
module tb_parser_seg_gather;
  localparam int W   = 512;
  localparam int KB  = W / 8;
  localparam int TW  = 128;
  localparam int NS  = 2;
  localparam int RW  = 160;
  localparam int RAW = 5;

  typedef struct {
    logic [NS*W-1:0] segs;
    logic [TW-1:0]   tuser;
    logic [RW-1:0]   bram;
    int              cyc;
    logic [31:0]     cnt;
    logic            sv;
    logic            bv;
  } pulse_t;

  logic clk, areset;
  logic ram_rd_en;
  logic [RAW-1:0] ram_rd_addr;
  logic [RW-1:0] ram_rd_data;
  logic [NS*W-1:0] segs_out;
  logic segs_out_valid, bram_out_valid;
  logic [TW-1:0] tuser_1st_out;
  logic [RW-1:0] bram_out;
  logic [31:0] pkt_cnt;
  logic [1:0] fsm_state;

  parser_seg_gather_if #(.DATA_WIDTH(W), .TUSER_WIDTH(TW)) bus ();

  parser_seg_gather #(
    .C_AXIS_DATA_WIDTH(W), .C_AXIS_TUSER_WIDTH(TW), .C_NUM_SEGS(NS),
    .C_PARSER_RAM_WIDTH(RW), .C_RAM_ADDR_WIDTH(RAW)
  ) dut (
    .clk(clk), .areset(areset), .s_axis(bus),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .segs_out(segs_out), .segs_out_valid(segs_out_valid), .tuser_1st_out(tuser_1st_out),
    .bram_out(bram_out), .bram_out_valid(bram_out_valid), .pkt_cnt(pkt_cnt),
    .fsm_state(fsm_state)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int exp_cnt = 0;
  logic sop_en_seen;
  logic [RAW-1:0] sop_addr_seen;
  logic [RW-1:0] ram_mem [32];
  pulse_t exp_q[$];
  pulse_t obs_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // RAM model: word valid one cycle after the strobe, garbage otherwise.
  always @(posedge clk) begin
    if (ram_rd_en) ram_rd_data <= ram_mem[ram_rd_addr];
    else ram_rd_data <= {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  end

  // Pulse collector.
  always @(negedge clk) begin
    if (!areset && (segs_out_valid || bram_out_valid)) begin
      pulse_t o;
      o.segs = segs_out; o.tuser = tuser_1st_out; o.bram = bram_out;
      o.cyc = cyc; o.cnt = pkt_cnt; o.sv = segs_out_valid; o.bv = bram_out_valid;
      obs_q.push_back(o);
    end
  end

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [TW-1:0] rand_tu();
    logic [TW-1:0] r;
    for (int i = 0; i < TW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    areset = 1'b1;
    bus.tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1 areset = 1'b0;
    exp_q.delete();
    obs_q.delete();
    exp_cnt = 0;
  endtask

  task automatic idle(input int n);
    bus.tvalid = 1'b0;
    bus.tready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one packet; the model records what the parser must emit and when.
  // keep_mode: 0 all bytes, 1 low 32 bytes, 2 random. stall_n: tready=0 cycles before beat 1.
  task automatic send_pkt(input int len, input logic [11:0] vid, input int keep_mode, input int stall_n);
    pulse_t e;
    logic [W-1:0] d;
    logic [KB-1:0] k;
    logic [TW-1:0] u;
    int last_gather;
    last_gather = (len < NS) ? len - 1 : NS - 1;
    e.segs = '0; e.tuser = '0; e.sv = 1'b1; e.bv = 1'b1;
    e.bram = ram_mem[vid[8:4]];
    for (int b = 0; b < len; b++) begin
      if (b == 1) begin
        for (int s = 0; s < stall_n; s++) begin
          bus.tdata = rand_w(); bus.tkeep = '1; bus.tuser = rand_tu();
          bus.tlast = 1'($urandom_range(0, 1)); bus.tvalid = 1'b1; bus.tready = 1'b0;
          @(posedge clk); #1;
        end
      end
      d = rand_w();
      if (b == 0) begin
        d[115:112] = vid[11:8];
        d[127:120] = vid[7:0];
      end
      if (keep_mode == 0) k = '1;
      else if (keep_mode == 1) k = 64'h0000_0000_FFFF_FFFF;
      else k = {$urandom(), $urandom()};
      u = rand_tu();
      if (b == 0) e.tuser = u;
      if (b < NS) begin
        for (int j = 0; j < KB; j++) e.segs[b*W + j*8 +: 8] = k[j] ? d[j*8 +: 8] : 8'h00;
      end
      bus.tdata = d; bus.tkeep = k; bus.tuser = u;
      bus.tlast = (b == len - 1); bus.tvalid = 1'b1; bus.tready = 1'b1;
      if (b == 0) begin
        #1 sop_en_seen = ram_rd_en;
        sop_addr_seen = ram_rd_addr;
      end
      if (b == last_gather) begin
        e.cyc = cyc + 2;
        exp_cnt++;
        e.cnt = 32'(exp_cnt);
        exp_q.push_back(e);
      end
      @(posedge clk); #1;
    end
    bus.tvalid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    areset = 1'b1;
    #1;
    total++; if (segs_out !== '0) begin bad++; $display("FAIL reset_segs got=%h exp=0", segs_out[63:0]); end
    total++; if (segs_out_valid !== 1'b0) begin bad++; $display("FAIL reset_segs_valid got=%b exp=0", segs_out_valid); end
    total++; if (bram_out !== '0) begin bad++; $display("FAIL reset_bram got=%h exp=0", bram_out); end
    total++; if (bram_out_valid !== 1'b0) begin bad++; $display("FAIL reset_bram_valid got=%b exp=0", bram_out_valid); end
    total++; if (tuser_1st_out !== '0) begin bad++; $display("FAIL reset_tuser got=%h exp=0", tuser_1st_out); end
    total++; if (pkt_cnt !== 32'd0) begin bad++; $display("FAIL reset_pkt_cnt got=%0d exp=0", pkt_cnt); end
    total++; if (ram_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b exp=0", ram_rd_en); end
    total++; if (fsm_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", fsm_state); end
    do_reset();
  endtask

  task automatic test_two_beat();
    pulse_t o, e;
    send_pkt(2, 12'h035, 0, 0);
    total++; if (sop_en_seen !== 1'b1) begin bad++; $display("FAIL two_beat_rd_en got=%b exp=1", sop_en_seen); end
    total++; if (sop_addr_seen !== 5'd3) begin bad++; $display("FAIL two_beat_rd_addr got=%0d exp=3", sop_addr_seen); end
    idle(6);
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL two_beat_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      total++; if (o.cyc !== e.cyc) begin bad++; $display("FAIL two_beat_cycle got=%0d exp=%0d", o.cyc, e.cyc); end
      total++; if ({o.sv, o.bv} !== 2'b11) begin bad++; $display("FAIL two_beat_valids got=%b exp=11", {o.sv, o.bv}); end
      total++; if (o.tuser !== e.tuser) begin bad++; $display("FAIL two_beat_tuser got=%h exp=%h", o.tuser, e.tuser); end
      total++; if (o.bram !== e.bram) begin bad++; $display("FAIL two_beat_bram got=%h exp=%h", o.bram, e.bram); end
      total++; if (o.cnt !== e.cnt) begin bad++; $display("FAIL two_beat_pkt_cnt got=%0d exp=%0d", o.cnt, e.cnt); end
      for (int k = 0; k < NS; k++) begin
        total++; if (o.segs[k*W +: W] !== e.segs[k*W +: W]) begin bad++; $display("FAIL two_beat_seg%0d got=%h exp=%h", k, o.segs[k*W +: W], e.segs[k*W +: W]); end
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_short_keep();
    pulse_t o, e;
    send_pkt(1, 12'h1A7, 1, 0);
    idle(6);
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL short_keep_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      total++; if (o.cyc !== e.cyc) begin bad++; $display("FAIL short_keep_cycle got=%0d exp=%0d", o.cyc, e.cyc); end
      total++; if ({o.sv, o.bv} !== 2'b11) begin bad++; $display("FAIL short_keep_valids got=%b exp=11", {o.sv, o.bv}); end
      total++; if (o.tuser !== e.tuser) begin bad++; $display("FAIL short_keep_tuser got=%h exp=%h", o.tuser, e.tuser); end
      total++; if (o.bram !== e.bram) begin bad++; $display("FAIL short_keep_bram got=%h exp=%h", o.bram, e.bram); end
      total++; if (o.cnt !== e.cnt) begin bad++; $display("FAIL short_keep_pkt_cnt got=%0d exp=%0d", o.cnt, e.cnt); end
      for (int k = 0; k < NS; k++) begin
        total++; if (o.segs[k*W +: W] !== e.segs[k*W +: W]) begin bad++; $display("FAIL short_keep_seg%0d got=%h exp=%h", k, o.segs[k*W +: W], e.segs[k*W +: W]); end
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_long_pkt();
    pulse_t o, e;
    send_pkt(5, 12'h2C4, 0, 0);
    send_pkt(2, 12'h0F3, 2, 0);
    idle(6);
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL long_pkt_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      total++; if (o.cyc !== e.cyc) begin bad++; $display("FAIL long_pkt_cycle got=%0d exp=%0d", o.cyc, e.cyc); end
      total++; if ({o.sv, o.bv} !== 2'b11) begin bad++; $display("FAIL long_pkt_valids got=%b exp=11", {o.sv, o.bv}); end
      total++; if (o.tuser !== e.tuser) begin bad++; $display("FAIL long_pkt_tuser got=%h exp=%h", o.tuser, e.tuser); end
      total++; if (o.bram !== e.bram) begin bad++; $display("FAIL long_pkt_bram got=%h exp=%h", o.bram, e.bram); end
      total++; if (o.cnt !== e.cnt) begin bad++; $display("FAIL long_pkt_pkt_cnt got=%0d exp=%0d", o.cnt, e.cnt); end
      for (int k = 0; k < NS; k++) begin
        total++; if (o.segs[k*W +: W] !== e.segs[k*W +: W]) begin bad++; $display("FAIL long_pkt_seg%0d got=%h exp=%h", k, o.segs[k*W +: W], e.segs[k*W +: W]); end
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    pulse_t o, e;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      logic [11:0] v;
      v = {3'b000, 5'(i * 3 + 1), 4'($urandom_range(0, 15))};
      send_pkt(1, v, 0, 0);
    end
    idle(6);
    total++; if (pkt_cnt !== 32'd10) begin bad++; $display("FAIL b2b_pkt_cnt_final got=%0d exp=10", pkt_cnt); end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      total++; if (o.cyc !== e.cyc) begin bad++; $display("FAIL b2b_cycle got=%0d exp=%0d", o.cyc, e.cyc); end
      total++; if ({o.sv, o.bv} !== 2'b11) begin bad++; $display("FAIL b2b_valids got=%b exp=11", {o.sv, o.bv}); end
      total++; if (o.tuser !== e.tuser) begin bad++; $display("FAIL b2b_tuser got=%h exp=%h", o.tuser, e.tuser); end
      total++; if (o.bram !== e.bram) begin bad++; $display("FAIL b2b_bram got=%h exp=%h", o.bram, e.bram); end
      total++; if (o.cnt !== e.cnt) begin bad++; $display("FAIL b2b_pkt_cnt got=%0d exp=%0d", o.cnt, e.cnt); end
      for (int k = 0; k < NS; k++) begin
        total++; if (o.segs[k*W +: W] !== e.segs[k*W +: W]) begin bad++; $display("FAIL b2b_seg%0d got=%h exp=%h", k, o.segs[k*W +: W], e.segs[k*W +: W]); end
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_stall();
    pulse_t o, e;
    send_pkt(2, 12'h3B9, 0, 3);
    send_pkt(3, 12'h055, 2, 2);
    idle(6);
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL stall_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      total++; if (o.cyc !== e.cyc) begin bad++; $display("FAIL stall_cycle got=%0d exp=%0d", o.cyc, e.cyc); end
      total++; if ({o.sv, o.bv} !== 2'b11) begin bad++; $display("FAIL stall_valids got=%b exp=11", {o.sv, o.bv}); end
      total++; if (o.tuser !== e.tuser) begin bad++; $display("FAIL stall_tuser got=%h exp=%h", o.tuser, e.tuser); end
      total++; if (o.bram !== e.bram) begin bad++; $display("FAIL stall_bram got=%h exp=%h", o.bram, e.bram); end
      total++; if (o.cnt !== e.cnt) begin bad++; $display("FAIL stall_pkt_cnt got=%0d exp=%0d", o.cnt, e.cnt); end
      for (int k = 0; k < NS; k++) begin
        total++; if (o.segs[k*W +: W] !== e.segs[k*W +: W]) begin bad++; $display("FAIL stall_seg%0d got=%h exp=%h", k, o.segs[k*W +: W], e.segs[k*W +: W]); end
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    pulse_t o, e;
    send_pkt(1, 12'h111, 0, 0);
    idle(4);
    obs_q.delete(); exp_q.delete();
    bus.tdata = rand_w(); bus.tkeep = '1; bus.tuser = rand_tu();
    bus.tlast = 1'b0; bus.tvalid = 1'b1; bus.tready = 1'b1;
    @(posedge clk); #1;
    bus.tvalid = 1'b0;
    #2 areset = 1'b1;
    repeat (2) @(posedge clk); #1;
    total++; if (segs_out !== '0) begin bad++; $display("FAIL reset_mid_segs got=%h exp=0", segs_out[63:0]); end
    total++; if (bram_out !== '0) begin bad++; $display("FAIL reset_mid_bram got=%h exp=0", bram_out); end
    total++; if (pkt_cnt !== 32'd0) begin bad++; $display("FAIL reset_mid_pkt_cnt got=%0d exp=0", pkt_cnt); end
    total++; if ({segs_out_valid, bram_out_valid} !== 2'b00) begin bad++; $display("FAIL reset_mid_valids got=%b exp=00", {segs_out_valid, bram_out_valid}); end
    areset = 1'b0;
    exp_cnt = 0;
    idle(3);
    send_pkt(2, 12'h2A0, 0, 0);
    idle(6);
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL reset_mid_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      total++; if (o.cyc !== e.cyc) begin bad++; $display("FAIL reset_mid_cycle got=%0d exp=%0d", o.cyc, e.cyc); end
      total++; if (o.tuser !== e.tuser) begin bad++; $display("FAIL reset_mid_tuser got=%h exp=%h", o.tuser, e.tuser); end
      total++; if (o.bram !== e.bram) begin bad++; $display("FAIL reset_mid_bram_pulse got=%h exp=%h", o.bram, e.bram); end
      total++; if (o.cnt !== e.cnt) begin bad++; $display("FAIL reset_mid_pulse_cnt got=%0d exp=%0d", o.cnt, e.cnt); end
      for (int k = 0; k < NS; k++) begin
        total++; if (o.segs[k*W +: W] !== e.segs[k*W +: W]) begin bad++; $display("FAIL reset_mid_seg%0d got=%h exp=%h", k, o.segs[k*W +: W], e.segs[k*W +: W]); end
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    pulse_t o, e;
    for (int i = 0; i < 40; i++) begin
      send_pkt($urandom_range(1, 6), 12'($urandom()), $urandom_range(0, 2), $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(6);
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL random_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      total++; if (o.cyc !== e.cyc) begin bad++; $display("FAIL random_cycle got=%0d exp=%0d", o.cyc, e.cyc); end
      total++; if ({o.sv, o.bv} !== 2'b11) begin bad++; $display("FAIL random_valids got=%b exp=11", {o.sv, o.bv}); end
      total++; if (o.tuser !== e.tuser) begin bad++; $display("FAIL random_tuser got=%h exp=%h", o.tuser, e.tuser); end
      total++; if (o.bram !== e.bram) begin bad++; $display("FAIL random_bram got=%h exp=%h", o.bram, e.bram); end
      total++; if (o.cnt !== e.cnt) begin bad++; $display("FAIL random_pkt_cnt got=%0d exp=%0d", o.cnt, e.cnt); end
      for (int k = 0; k < NS; k++) begin
        total++; if (o.segs[k*W +: W] !== e.segs[k*W +: W]) begin bad++; $display("FAIL random_seg%0d got=%h exp=%h", k, o.segs[k*W +: W], e.segs[k*W +: W]); end
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    areset = 1'b1;
    bus.tdata = '0; bus.tkeep = '0; bus.tuser = '0;
    bus.tlast = 1'b0; bus.tvalid = 1'b0; bus.tready = 1'b1;
    for (int i = 0; i < 32; i++) ram_mem[i] = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_two_beat();
    test_short_keep();
    test_long_pkt();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
